imm_encoder: RTL and testbench
==============================

# imm_encoder

Iterative immediate encoder: takes a 32-bit constant plus an immediate-source selector and produces the packed immediate field that the datapath immediate extender expands back to exactly the same 32-bit value. It sits in the instruction-generation path (self-test instruction builder and debug patch unit) and is the inverse of the extender's three formats: rotated data-processing immediate, 12-bit memory offset and 24-bit branch offset. The data-processing search is sequential, testing one rotation per cycle. Input and output use valid/ready handshakes.

## Interface
- No parameters; all widths fixed by the instruction format.
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  request present
- in_ready  out  1  high only in IDLE
- value  in  32  constant to encode; sampled on input handshake
- imm_src  in  2  0 data-processing, 1 memory, 2 branch, 3 reserved
- out_valid  out  1  result present; held until consumed
- out_ready  in  1  consumer accepts result
- immediate  out  24  encoded field, format per imm_src; 0 when ok=0
- ok  out  1  1 = value encodable; 0 = not encodable / reserved imm_src

## Operation
- States: IDLE, SEARCH, DONE. in_ready = (state==IDLE).
- IDLE: on in_valid&&in_ready, capture value into a rotate register, capture imm_src, clear 4-bit rotation counter r, go to SEARCH.
- SEARCH, imm_src=0: each cycle test the rotate register w = ROL(value, 2r). If w[31:8]==0: immediate={12'b0, r[3:0], w[7:0]}, ok=1, go DONE. Else if r==15: immediate=0, ok=0, go DONE. Else w<=ROL(w,2), r<=r+1.
- Smallest matching r always chosen (value 0 gives r=0, imm8=0). Result satisfies ROR32(zext(imm8), 2r) == value.
- SEARCH, imm_src=1: ok = (value[31:12]==0); immediate = ok ? {12'b0, value[11:0]} : 0. One SEARCH cycle, go DONE.
- SEARCH, imm_src=2: ok = (value[1:0]==0) && value[31:25] all equal; immediate = ok ? value[25:2] : 0. One SEARCH cycle, go DONE.
- SEARCH, imm_src=3: ok=0, immediate=0, go DONE.
- DONE: out_valid=1; immediate/ok stable. On out_ready go IDLE. No same-cycle turnaround: in_ready rises the cycle after the output handshake.
- in_valid/value/imm_src ignored outside IDLE; changes during SEARCH do not affect the result.

## Timing
- Reset (rst_n low, async): state=IDLE, out_valid=0, immediate=0, ok=0, r=0; in_ready=1 once state is IDLE. Reset mid-SEARCH or mid-DONE aborts the request with no output; held result is discarded.
- Edge E0 = input handshake. Modes 1/2/3: out_valid high after E1 (latency 1). Mode 0 with match at r: out_valid high after E(r+1) (latency 1..16). Mode 0 failure: out_valid after E16.
- Maximum occupancy: 16 SEARCH cycles + DONE cycles held by back-pressure; throughput at most one request per 2 + latency cycles.
- out_valid never drops without out_ready; immediate/ok never change while out_valid=1.
- out_ready high before out_valid: result consumed on the first DONE cycle.

## Test plan
- Mode 0, value 0x000000AB -> out_valid 1 cycle after accept, immediate 0x0000AB, ok=1; value 0 -> immediate 0x000000, ok=1.
- Mode 0, value 0xFF000000 -> immediate 0x0004FF after 5 cycles; 0xF000000F -> 0x0002FF after 3 cycles; 0x000003FC -> 0x000FFF after 16 cycles.
- Mode 0, value 0x00000101 -> ok=0, immediate 0, out_valid after 16 cycles; mode 3 any value -> ok=0 after 1 cycle.
- Mode 1, 0x00000FFF -> 0x000FFF ok=1; 0x00001000 -> ok=0. Mode 2, 0xFFFFFFFC -> 0xFFFFFF ok=1; 0x02000000 -> ok=0; 0x00000006 -> ok=0.
- Handshake: out_ready low 5 cycles -> out_valid/immediate held constant, in_ready=0; in_valid toggling with new value during SEARCH -> result unchanged.
- Assert rst_n low mid-SEARCH of 0x000003FC -> out_valid/immediate/ok 0 immediately, in_ready 1; next request 0xAB completes normally. Random mode-0 values: re-expanding each ok=1 result reproduces value; every ok=0 value confirmed unencodable by exhaustive model.

Source files
------------

// File: rtl/imm_encoder.sv
// rtl/imm_encoder.sv - iterative immediate encoder (rotated, memory offset, branch offset formats)
module imm_encoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] value,
    input  logic [1:0]  imm_src,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [23:0] immediate,
    output logic        ok
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [1:0] SRC_DP  = 2'd0;
    localparam logic [1:0] SRC_MEM = 2'd1;
    localparam logic [1:0] SRC_BR  = 2'd2;

    state_t      state, state_n;
    logic [31:0] rot, rot_n;
    logic [1:0]  src, src_n;
    logic [3:0]  r, r_n;
    logic [23:0] imm_n;
    logic        ok_n;
    logic        br_sign_ok;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // Branch offsets must sign-extend from bit 25: bits 31..25 all ones or all zeros.
    assign br_sign_ok = (&rot[31:25]) | ~(|rot[31:25]);

    // State register and captured request/result; reset discards any request in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rot       <= 32'd0;
            src       <= 2'd0;
            r         <= 4'd0;
            immediate <= 24'd0;
            ok        <= 1'b0;
        end else begin
            state     <= state_n;
            rot       <= rot_n;
            src       <= src_n;
            r         <= r_n;
            immediate <= imm_n;
            ok        <= ok_n;
        end
    end

    // Next-state and datapath: one rotation tried per SEARCH cycle, smallest rotation wins.
    always_comb begin
        state_n = state;
        rot_n   = rot;
        src_n   = src;
        r_n     = r;
        imm_n   = immediate;
        ok_n    = ok;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    rot_n   = value;
                    src_n   = imm_src;
                    r_n     = 4'd0;
                    imm_n   = 24'd0;
                    ok_n    = 1'b0;
                    state_n = SEARCH;
                end
            end
            SEARCH: begin
                state_n = DONE;
                case (src)
                    SRC_DP: begin
                        if (rot[31:8] == 24'd0) begin
                            imm_n = {12'd0, r, rot[7:0]};
                            ok_n  = 1'b1;
                        end else if (r == 4'd15) begin
                            imm_n = 24'd0;
                            ok_n  = 1'b0;
                        end else begin
                            state_n = SEARCH;
                            rot_n   = {rot[29:0], rot[31:30]};
                            r_n     = r + 4'd1;
                        end
                    end
                    SRC_MEM: begin
                        ok_n  = (rot[31:12] == 20'd0);
                        imm_n = (rot[31:12] == 20'd0) ? {12'd0, rot[11:0]} : 24'd0;
                    end
                    SRC_BR: begin
                        ok_n  = (rot[1:0] == 2'd0) && br_sign_ok;
                        imm_n = ((rot[1:0] == 2'd0) && br_sign_ok) ? rot[25:2] : 24'd0;
                    end
                    default: begin
                        ok_n  = 1'b0;
                        imm_n = 24'd0;
                    end
                endcase
            end
            DONE: begin
                if (out_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_imm_encoder.sv
// tb/tb_imm_encoder.sv - self-checking bench for imm_encoder
module tb_imm_encoder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] value;
    logic [1:0]  imm_src;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] immediate;
    logic        ok;

    int errors = 0;
    int checks = 0;

    imm_encoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .value     (value),
        .imm_src   (imm_src),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .immediate (immediate),
        .ok        (ok)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] v;
        logic [1:0]  s;
        logic [23:0] imm;
        logic        okv;
        int          lat;
    } vec_t;

    function automatic logic [31:0] rol32(input logic [31:0] x, input int n);
        int k;
        k = n % 32;
        if (k == 0) return x;
        return (x << k) | (x >> (32 - k));
    endfunction

    function automatic logic [31:0] ror32(input logic [31:0] x, input int n);
        return rol32(x, (32 - (n % 32)) % 32);
    endfunction

    // Reference: the immediate format rules written as plain arithmetic.
    task automatic ref_model(input logic [31:0] v, input logic [1:0] s,
                             output logic [23:0] imm, output logic okv, output int lat);
        int sv;
        bit found;
        imm = 24'd0;
        okv = 1'b0;
        lat = 1;
        sv  = int'(v);
        case (s)
            2'd0: begin
                found = 1'b0;
                lat   = 16;
                for (int rr = 0; rr < 16; rr++) begin
                    logic [31:0] w;
                    logic [3:0]  r4;
                    w  = rol32(v, 2 * rr);
                    r4 = rr[3:0];
                    if (!found && w < 32'd256) begin
                        found = 1'b1;
                        imm   = {12'd0, r4, w[7:0]};
                        okv   = 1'b1;
                        lat   = rr + 1;
                    end
                end
            end
            2'd1: begin
                okv = (v < 32'd4096);
                imm = okv ? v[23:0] : 24'd0;
            end
            2'd2: begin
                okv = (v % 4 == 0) && (sv >= -(1 << 25)) && (sv < (1 << 25));
                imm = okv ? v[25:2] : 24'd0;
            end
            default: begin
                okv = 1'b0;
            end
        endcase
    endtask

    function automatic bit encodable_exhaustive(input logic [31:0] v);
        for (int rr = 0; rr < 16; rr++)
            for (int i = 0; i < 256; i++)
                if (ror32(32'(i), 2 * rr) == v) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // One request through both handshakes; optional back-pressure and input noise during SEARCH.
    task automatic run_req(input logic [31:0] v, input logic [1:0] s, input int hold, input bit noise,
                           output logic [23:0] imm, output logic okv, output int lat);
        @(negedge clk);
        chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        value    = v;
        imm_src  = s;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        do begin
            if (noise) begin
                in_valid = 1'($urandom % 2);
                value    = $urandom;
                imm_src  = 2'($urandom % 4);
            end
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 40);
        in_valid = 1'b0;
        if (!out_valid) begin
            checks++;
            errors++;
            $display("FAIL timeout: out_valid got 0 want 1 after %0d cycles", lat);
        end
        imm = immediate;
        okv = ok;
        for (int h = 0; h < hold; h++) begin
            chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
            @(negedge clk);
            chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_immediate", {8'd0, immediate}, {8'd0, imm});
            chk("hold_ok", {31'd0, ok}, {31'd0, okv});
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("consumed_out_valid", {31'd0, out_valid}, 32'd0);
        chk("consumed_in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    vec_t        tbl[13];
    logic [23:0] got_imm, exp_imm;
    logic        got_ok, exp_ok;
    int          got_lat, exp_lat;
    logic [31:0] rv;

    initial begin
        tbl[0]  = '{32'h0000_00AB, 2'd0, 24'h0000AB, 1'b1, 1};
        tbl[1]  = '{32'h0000_0000, 2'd0, 24'h000000, 1'b1, 1};
        tbl[2]  = '{32'hFF00_0000, 2'd0, 24'h0004FF, 1'b1, 5};
        tbl[3]  = '{32'hF000_000F, 2'd0, 24'h0002FF, 1'b1, 3};
        tbl[4]  = '{32'h0000_03FC, 2'd0, 24'h000FFF, 1'b1, 16};
        tbl[5]  = '{32'h0000_0101, 2'd0, 24'h000000, 1'b0, 16};
        tbl[6]  = '{32'h1234_5678, 2'd3, 24'h000000, 1'b0, 1};
        tbl[7]  = '{32'h0000_0FFF, 2'd1, 24'h000FFF, 1'b1, 1};
        tbl[8]  = '{32'h0000_1000, 2'd1, 24'h000000, 1'b0, 1};
        tbl[9]  = '{32'hFFFF_FFFC, 2'd2, 24'hFFFFFF, 1'b1, 1};
        tbl[10] = '{32'h0200_0000, 2'd2, 24'h000000, 1'b0, 1};
        tbl[11] = '{32'h0000_0006, 2'd2, 24'h000000, 1'b0, 1};
        tbl[12] = '{32'h01FF_FFFC, 2'd2, 24'h7FFFFF, 1'b1, 1};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        value     = 32'd0;
        imm_src   = 2'd0;
        out_ready = 1'b0;
        #1;
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_immediate", {8'd0, immediate}, 32'd0);
        chk("reset_ok", {31'd0, ok}, 32'd0);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table.
        foreach (tbl[i]) begin
            run_req(tbl[i].v, tbl[i].s, 0, 1'b0, got_imm, got_ok, got_lat);
            chk($sformatf("tbl%0d_imm", i), {8'd0, got_imm}, {8'd0, tbl[i].imm});
            chk($sformatf("tbl%0d_ok", i), {31'd0, got_ok}, {31'd0, tbl[i].okv});
            chk($sformatf("tbl%0d_lat", i), 32'(got_lat), 32'(tbl[i].lat));
        end

        // Back-pressure for five cycles with the result held.
        run_req(32'hFF00_0000, 2'd0, 5, 1'b0, got_imm, got_ok, got_lat);
        chk("bp_imm", {8'd0, got_imm}, 32'h0004FF);
        chk("bp_ok", {31'd0, got_ok}, 32'd1);

        // Input noise during a long search must not disturb the result.
        run_req(32'h0000_03FC, 2'd0, 2, 1'b1, got_imm, got_ok, got_lat);
        chk("noise_imm", {8'd0, got_imm}, 32'h000FFF);
        chk("noise_ok", {31'd0, got_ok}, 32'd1);
        chk("noise_lat", 32'(got_lat), 32'd16);

        // out_ready already high: consumed on the first DONE cycle.
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        value     = 32'h0000_0123;
        imm_src   = 2'd1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("early_ready_valid", {31'd0, out_valid}, 32'd1);
        chk("early_ready_imm", {8'd0, immediate}, 32'h000123);
        @(negedge clk);
        chk("early_ready_consumed", {31'd0, out_valid}, 32'd0);
        chk("early_ready_in_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b0;

        // Reset in the middle of a search.
        in_valid = 1'b1;
        value    = 32'h0000_03FC;
        imm_src  = 2'd0;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_search_in_ready", {31'd0, in_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("rst_search_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_search_imm", {8'd0, immediate}, 32'd0);
        chk("rst_search_ok", {31'd0, ok}, 32'd0);
        chk("rst_search_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset while a result is held in DONE.
        in_valid = 1'b1;
        value    = 32'h0000_0FFF;
        imm_src  = 2'd1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_done_valid", {31'd0, out_valid}, 32'd1);
        chk("pre_rst_done_imm", {8'd0, immediate}, 32'h000FFF);
        rst_n = 1'b0;
        #1;
        chk("rst_done_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_done_imm", {8'd0, immediate}, 32'd0);
        chk("rst_done_ok", {31'd0, ok}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_req(32'h0000_00AB, 2'd0, 0, 1'b0, got_imm, got_ok, got_lat);
        chk("post_rst_imm", {8'd0, got_imm}, 32'h0000AB);
        chk("post_rst_ok", {31'd0, got_ok}, 32'd1);
        chk("post_rst_lat", 32'(got_lat), 32'd1);

        // Randomized requests against the reference model.
        for (int n = 0; n < 200; n++) begin
            logic [1:0] s;
            case ($urandom % 4)
                0: rv = ror32(32'($urandom_range(0, 255)), 2 * int'($urandom_range(0, 15)));
                1: rv = $urandom;
                2: rv = 32'($urandom_range(0, 8191));
                default: rv = ror32(32'($urandom_range(0, 1023)), int'($urandom_range(0, 31)));
            endcase
            s = (n % 3 == 0) ? 2'($urandom % 4) : 2'd0;
            ref_model(rv, s, exp_imm, exp_ok, exp_lat);
            run_req(rv, s, int'($urandom % 3), 1'($urandom % 2), got_imm, got_ok, got_lat);
            chk($sformatf("rnd%0d_imm v=%h s=%0d", n, rv, s), {8'd0, got_imm}, {8'd0, exp_imm});
            chk($sformatf("rnd%0d_ok v=%h s=%0d", n, rv, s), {31'd0, got_ok}, {31'd0, exp_ok});
            chk($sformatf("rnd%0d_lat v=%h s=%0d", n, rv, s), 32'(got_lat), 32'(exp_lat));
            if (s == 2'd0) begin
                if (got_ok)
                    chk($sformatf("rnd%0d_reexpand", n),
                        ror32({24'd0, got_imm[7:0]}, 2 * int'(got_imm[11:8])), rv);
                else
                    chk($sformatf("rnd%0d_unencodable v=%h", n, rv),
                        {31'd0, encodable_exhaustive(rv)}, 32'd0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
